pyramid_dim_scheduler: RTL and testbench

PYRAMID_DIM_SCHEDULER -- requirements
Module: pyramid_dim_scheduler

---
 rtl/pyramid_dim_scheduler_pkg.sv | 32 +++
 rtl/pyramid_dim_scheduler_calc.sv | 96 +++++++++
 rtl/pyramid_dim_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pyramid_dim_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyramid_dim_scheduler_pkg.sv
// Shared types and constants for the image-pyramid dimension scheduler.
package pyramid_dim_scheduler_pkg;

    localparam int unsigned DEF_COORD_BITS = 16;
    localparam int unsigned DEF_LEVEL_BITS = 4;
    localparam int unsigned DEF_MIN_DIM    = 16;

    // Sequencer states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EMIT   = 3'd1,
        ST_CALC_W = 3'd2,
        ST_CALC_H = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    // One pyramid level as presented to the consumer (default widths).
    typedef struct packed {
        logic [DEF_LEVEL_BITS-1:0] index;
        logic [DEF_COORD_BITS-1:0] width;
        logic [DEF_COORD_BITS-1:0] height;
    } level_rec_t;

    // True when both dimensions are large enough to be emitted as a level.
    function automatic logic dims_ok(input logic [31:0] w,
                                     input logic [31:0] h,
                                     input logic [31:0] min_dim);
        return (w >= min_dim) && (h >= min_dim);
    endfunction

endpackage

// File: rtl/pyramid_dim_scheduler_calc.sv
// Shared 4/5 down-scaler: new = ((old-1)*4 div 5)+1.
// Bit-serial restoring divide by 5; result is signalled by a one-cycle out_valid.
module DimensionCalculator_4_5
    import pyramid_dim_scheduler_pkg::*;
#(
    parameter int unsigned COORD_BITS = DEF_COORD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [COORD_BITS-1:0] in_dim,
    output logic                  out_valid,
    output logic [COORD_BITS-1:0] out_dim
);

    localparam int unsigned DIV_BITS = COORD_BITS + 2;
    localparam int unsigned CNT_BITS = $clog2(DIV_BITS + 1);

    logic                  active_r;
    logic [CNT_BITS-1:0]   cnt_r;
    logic [DIV_BITS-1:0]   dividend_r;
    logic [DIV_BITS-1:0]   quot_r;
    logic [2:0]            rem_r;
    logic                  out_valid_r;
    logic [COORD_BITS-1:0] out_dim_r;

    logic [3:0]            rem_shift_s;
    logic [2:0]            rem_next_s;
    logic                  qbit_s;
    logic [DIV_BITS-1:0]   quot_next_s;
    logic [COORD_BITS-1:0] dim_minus1_s;

    // One restoring-division step: shift in the next dividend bit, subtract 5 if it fits.
    always_comb begin
        rem_shift_s = {rem_r, dividend_r[DIV_BITS-1]};
        rem_next_s  = rem_shift_s[2:0];
        qbit_s      = 1'b0;
        if (rem_shift_s >= 4'd5) begin
            rem_next_s = 3'(rem_shift_s - 4'd5);
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = rem_shift_s[2:0];
            qbit_s     = 1'b0;
        end
        quot_next_s = {quot_r[DIV_BITS-2:0], qbit_s};
    end

    // A zero input is clamped so the subtraction cannot wrap.
    always_comb begin
        if (in_dim == {COORD_BITS{1'b0}}) begin
            dim_minus1_s = {COORD_BITS{1'b0}};
        end else begin
            dim_minus1_s = in_dim - COORD_BITS'(1);
        end
    end

    // Division sequencer: load on request, step once per cycle, pulse the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r    <= 1'b0;
            cnt_r       <= {CNT_BITS{1'b0}};
            dividend_r  <= {DIV_BITS{1'b0}};
            quot_r      <= {DIV_BITS{1'b0}};
            rem_r       <= 3'd0;
            out_valid_r <= 1'b0;
            out_dim_r   <= {COORD_BITS{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            if (in_valid && !active_r) begin
                active_r   <= 1'b1;
                cnt_r      <= CNT_BITS'(DIV_BITS);
                dividend_r <= {dim_minus1_s, 2'b00};
                quot_r     <= {DIV_BITS{1'b0}};
                rem_r      <= 3'd0;
            end else if (active_r) begin
                dividend_r <= {dividend_r[DIV_BITS-2:0], 1'b0};
                quot_r     <= quot_next_s;
                rem_r      <= rem_next_s;
                cnt_r      <= cnt_r - CNT_BITS'(1);
                if (cnt_r == CNT_BITS'(1)) begin
                    active_r    <= 1'b0;
                    out_valid_r <= 1'b1;
                    out_dim_r   <= COORD_BITS'(quot_next_s) + COORD_BITS'(1);
                end else begin
                    active_r <= 1'b1;
                end
            end else begin
                active_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_dim   = out_dim_r;

endmodule

// File: rtl/pyramid_dim_scheduler.sv
// Emits successive 4/5-scaled pyramid levels until the level budget is used
// or a dimension falls below MIN_DIM. One calculator is shared by width and height.
module pyramid_dim_scheduler
    import pyramid_dim_scheduler_pkg::*;
#(
    parameter int unsigned COORD_BITS = DEF_COORD_BITS,
    parameter int unsigned LEVEL_BITS = DEF_LEVEL_BITS,
    parameter int unsigned MIN_DIM    = DEF_MIN_DIM
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [COORD_BITS-1:0] in_width,
    input  logic [COORD_BITS-1:0] in_height,
    input  logic [LEVEL_BITS-1:0] in_levels,
    output logic                  level_valid,
    input  logic                  level_ready,
    output logic [LEVEL_BITS-1:0] level_index,
    output logic [COORD_BITS-1:0] level_width,
    output logic [COORD_BITS-1:0] level_height,
    output logic                  busy,
    output logic                  done,
    output logic [LEVEL_BITS-1:0] level_count,
    output logic                  error
);

    state_e                state_r, state_s;
    logic [LEVEL_BITS-1:0] idx_r, idx_s;
    logic [LEVEL_BITS-1:0] count_r, count_s;
    logic [LEVEL_BITS-1:0] levels_r, levels_s;
    logic [COORD_BITS-1:0] width_r, width_s;
    logic [COORD_BITS-1:0] height_r, height_s;
    logic                  error_r, error_s;
    logic                  calc_in_valid_r, calc_in_valid_s;
    logic                  level_valid_r, busy_r, done_r;

    logic [COORD_BITS-1:0] calc_in_dim_s;
    logic                  calc_out_valid_s;
    logic [COORD_BITS-1:0] calc_out_dim_s;
    logic [LEVEL_BITS-1:0] count_inc_s;
    logic                  input_bad_s;

    assign count_inc_s = count_r + LEVEL_BITS'(1);
    assign input_bad_s = (32'(in_width) < 32'(MIN_DIM)) ||
                         (32'(in_height) < 32'(MIN_DIM)) ||
                         (in_levels == {LEVEL_BITS{1'b0}});

    // Next-state and datapath update for the level sequencer.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        count_s  = count_r;
        levels_s = levels_r;
        width_s  = width_r;
        height_s = height_r;
        error_s  = error_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    levels_s = in_levels;
                    width_s  = in_width;
                    height_s = in_height;
                    idx_s    = {LEVEL_BITS{1'b0}};
                    count_s  = {LEVEL_BITS{1'b0}};
                    if (input_bad_s) begin
                        error_s = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        error_s = 1'b0;
                        state_s = ST_EMIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (level_ready) begin
                    count_s = count_inc_s;
                    if (count_inc_s == levels_r) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_CALC_W;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_CALC_W: begin
                if (calc_out_valid_s) begin
                    width_s = calc_out_dim_s;
                    state_s = ST_CALC_H;
                end else begin
                    state_s = ST_CALC_W;
                end
            end
            ST_CALC_H: begin
                if (calc_out_valid_s) begin
                    height_s = calc_out_dim_s;
                    state_s  = ST_CHECK;
                end else begin
                    state_s = ST_CALC_H;
                end
            end
            ST_CHECK: begin
                if (dims_ok(32'(width_r), 32'(height_r), 32'(MIN_DIM))) begin
                    idx_s   = idx_r + LEVEL_BITS'(1);
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Exactly one calculator request on entry to each CALC state.
        calc_in_valid_s = ((state_s == ST_CALC_W) && (state_r != ST_CALC_W)) ||
                          ((state_s == ST_CALC_H) && (state_r != ST_CALC_H));
    end

    // Calculator operand follows the dimension being recomputed.
    always_comb begin
        if (state_r == ST_CALC_H) begin
            calc_in_dim_s = height_r;
        end else begin
            calc_in_dim_s = width_r;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            idx_r           <= {LEVEL_BITS{1'b0}};
            count_r         <= {LEVEL_BITS{1'b0}};
            levels_r        <= {LEVEL_BITS{1'b0}};
            width_r         <= {COORD_BITS{1'b0}};
            height_r        <= {COORD_BITS{1'b0}};
            error_r         <= 1'b0;
            calc_in_valid_r <= 1'b0;
            level_valid_r   <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            idx_r           <= idx_s;
            count_r         <= count_s;
            levels_r        <= levels_s;
            width_r         <= width_s;
            height_r        <= height_s;
            error_r         <= error_s;
            calc_in_valid_r <= calc_in_valid_s;
            level_valid_r   <= (state_s == ST_EMIT);
            busy_r          <= (state_s != ST_IDLE);
            done_r          <= (state_s == ST_FINISH);
        end
    end

    DimensionCalculator_4_5 #(
        .COORD_BITS (COORD_BITS)
    ) u_calc (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_valid  (calc_in_valid_r),
        .in_dim    (calc_in_dim_s),
        .out_valid (calc_out_valid_s),
        .out_dim   (calc_out_dim_s)
    );

    assign level_valid  = level_valid_r;
    assign level_index  = idx_r;
    assign level_width  = width_r;
    assign level_height = height_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign level_count  = count_r;
    assign error        = error_r;

endmodule

// File: tb/tb_pyramid_dim_scheduler.sv
// Self-checking bench for pyramid_dim_scheduler: table of sequences with a
// scoreboard of expected levels, plus hand-written stall and reset sequences.
module tb_pyramid_dim_scheduler;

    localparam int MIN_D = 16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] in_width;
    logic [15:0] in_height;
    logic [3:0]  in_levels;
    logic        level_valid;
    logic        level_ready;
    logic [3:0]  level_index;
    logic [15:0] level_width;
    logic [15:0] level_height;
    logic        busy;
    logic        done;
    logic [3:0]  level_count;
    logic        error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int w;
        int h;
    } lvl_t;

    typedef struct {
        int w;
        int h;
        int lv;
        int mode;       // 0 ready high, 1 random ready, 2 stray starts, 3 stall at level 1
        int exp_count;
        int exp_err;
    } vec_t;

    lvl_t q[$];
    vec_t tbl[7];

    pyramid_dim_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_width     (in_width),
        .in_height    (in_height),
        .in_levels    (in_levels),
        .level_valid  (level_valid),
        .level_ready  (level_ready),
        .level_index  (level_index),
        .level_width  (level_width),
        .level_height (level_height),
        .busy         (busy),
        .done         (done),
        .level_count  (level_count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: push the expected level list for one request.
    task automatic model_push(input int w, input int h, input int lv);
        int cw;
        int ch;
        int n;
        cw = w;
        ch = h;
        n  = 0;
        q.delete();
        if (w >= MIN_D && h >= MIN_D && lv != 0) begin
            for (int i = 0; i < 16; i++) begin
                lvl_t e;
                e.idx = i;
                e.w   = cw;
                e.h   = ch;
                q.push_back(e);
                n++;
                if (n == lv) break;
                cw = ((cw - 1) * 4) / 5 + 1;
                ch = ((ch - 1) * 4) / 5 + 1;
                if (cw < MIN_D || ch < MIN_D) break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " level_valid"}, int'(level_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " error"}, int'(error), 0);
        chk({tag, " level_count"}, int'(level_count), 0);
        chk({tag, " level_index"}, int'(level_index), 0);
        chk({tag, " level_width"}, int'(level_width), 0);
        chk({tag, " level_height"}, int'(level_height), 0);
    endtask

    // Run one full request, comparing every handshaken level against the scoreboard.
    task automatic run_seq(input vec_t v, input string tag);
        int  cyc;
        int  finished;
        int  seen;
        int  stall;
        int  hs0_cyc;
        int  noise1;
        model_push(v.w, v.h, v.lv);
        finished = 0;
        seen     = 0;
        stall    = 0;
        hs0_cyc  = -100;
        noise1   = 0;
        @(negedge clk);
        in_width  = 16'(v.w);
        in_height = 16'(v.h);
        in_levels = 4'(v.lv);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 600; cyc++) begin
            start = 1'b0;
            if (done) begin
                chk({tag, " level_count"}, int'(level_count), v.exp_count);
                chk({tag, " error"}, int'(error), v.exp_err);
                chk({tag, " missing levels"}, q.size(), 0);
                if (v.exp_err != 0) begin
                    chk({tag, " done latency ok"}, int'(cyc <= 1), 1);
                    chk({tag, " levels seen"}, seen, 0);
                end
                if (v.mode == 2) start = 1'b1;
                finished = 1;
                break;
            end
            if (cyc == 0) chk({tag, " busy"}, int'(busy), 1);
            case (v.mode)
                1: level_ready = 1'($urandom_range(0, 1));
                3: begin
                    if (level_valid && level_index == 4'd1 && stall < 10) begin
                        level_ready = 1'b0;
                        chk({tag, " stall width"}, int'(level_width), 512);
                        chk({tag, " stall height"}, int'(level_height), 384);
                        stall++;
                    end else begin
                        level_ready = 1'b1;
                    end
                end
                default: level_ready = 1'b1;
            endcase
            if (v.mode == 2) begin
                if (level_valid && level_index == 4'd0 && noise1 == 0) begin
                    in_width  = 16'd32;
                    in_height = 16'd32;
                    in_levels = 4'd1;
                    start     = 1'b1;
                    noise1    = 1;
                end else if (cyc == hs0_cyc + 3) begin
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (level_valid && level_ready) begin
                seen++;
                if (q.size() == 0) begin
                    chk({tag, " unexpected level"}, int'(level_index), -1);
                end else begin
                    lvl_t e;
                    e = q.pop_front();
                    chk({tag, " index"}, int'(level_index), e.idx);
                    chk({tag, " width"}, int'(level_width), e.w);
                    chk({tag, " height"}, int'(level_height), e.h);
                end
                if (level_index == 4'd0) hs0_cyc = cyc;
            end
            @(negedge clk);
        end
        chk({tag, " timeout"}, finished, 1);
        if (v.mode == 3) chk({tag, " stall cycles"}, stall, 10);
        @(negedge clk);
        start = 1'b0;
        if (v.mode == 2) begin
            chk({tag, " idle after stray start"}, int'(busy), 0);
            @(negedge clk);
            chk({tag, " still idle"}, int'(busy), 0);
            chk({tag, " no level after finish"}, int'(level_valid), 0);
        end
        level_ready = 1'b1;
    endtask

    initial begin
        int   hs1;
        vec_t v;

        tbl[0] = '{w: 640,  h: 480, lv: 3,  mode: 0, exp_count: 3, exp_err: 0};
        tbl[1] = '{w: 20,   h: 20,  lv: 8,  mode: 0, exp_count: 2, exp_err: 0};
        tbl[2] = '{w: 8,    h: 100, lv: 5,  mode: 0, exp_count: 0, exp_err: 1};
        tbl[3] = '{w: 640,  h: 480, lv: 3,  mode: 3, exp_count: 3, exp_err: 0};
        tbl[4] = '{w: 640,  h: 480, lv: 4,  mode: 2, exp_count: 4, exp_err: 0};
        tbl[5] = '{w: 1000, h: 50,  lv: 15, mode: 1, exp_count: 6, exp_err: 0};
        tbl[6] = '{w: 100,  h: 100, lv: 0,  mode: 0, exp_count: 0, exp_err: 1};

        reset_n     = 1'b0;
        start       = 1'b0;
        level_ready = 1'b1;
        in_width    = 16'd0;
        in_height   = 16'd0;
        in_levels   = 4'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_seq(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of level-1 height calculation.
        @(negedge clk);
        in_width    = 16'd640;
        in_height   = 16'd480;
        in_levels   = 4'd3;
        level_ready = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs1   = 0;
        for (int c = 0; c < 200; c++) begin
            if (level_valid && level_index == 4'd1) begin
                hs1 = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst reached level1", hs1, 1);
        repeat (28) @(negedge clk);
        chk("rst pre busy", int'(busy), 1);
        chk("rst pre valid", int'(level_valid), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (30) @(negedge clk);
        chk_reset_outputs("midrst hold");
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post rst idle", int'(busy), 0);
        chk("post rst no done", int'(done), 0);
        v = '{w: 640, h: 480, lv: 3, mode: 0, exp_count: 3, exp_err: 0};
        run_seq(v, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
